// File: rtl/m4sram_xpose_ctrl_pkg.sv
// m4sram_xpose_ctrl_pkg: shared sizes and state encoding for the 4x4 corner-turn controller
package m4sram_xpose_ctrl_pkg;
  localparam int N = 4;
  localparam int DW = 64;
  localparam int AW = 2;
  typedef enum logic {WR, RD} state_t;
endpackage

// File: rtl/m4sram_xpose_ctrl_rot4.sv
// m4sram_xpose_ctrl_rot4: 4-lane rotator, 2-bit amount, selectable direction
// Ports: d0..d3 lanes in; amt rotation; dir 0: q[b]=d[b-amt], 1: q[b]=d[b+amt]; q0..q3 lanes out
module m4sram_xpose_ctrl_rot4
  import m4sram_xpose_ctrl_pkg::*;
#(
  parameter int W = DW
) (
  input  logic [W-1:0]  d0,
  input  logic [W-1:0]  d1,
  input  logic [W-1:0]  d2,
  input  logic [W-1:0]  d3,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  output logic [W-1:0]  q0,
  output logic [W-1:0]  q1,
  output logic [W-1:0]  q2,
  output logic [W-1:0]  q3
);
  logic [W-1:0] a [N];
  logic [W-1:0] y [N];
  assign a[0] = d0;
  assign a[1] = d1;
  assign a[2] = d2;
  assign a[3] = d3;
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [AW-1:0] s;
    assign s = dir ? AW'(i) + amt : AW'(i) - amt;
    assign y[i] = a[s];
  end
  assign q0 = y[0];
  assign q1 = y[1];
  assign q2 = y[2];
  assign q3 = y[3];
endmodule

// File: rtl/m4sram_xpose_ctrl.sv
// m4sram_xpose_ctrl: drives a 4-bank SRAM as a 4x4 transpose buffer (rows in, columns out)
// Ports: in_valid/in_ready/in_d* row beats; out_valid/out_d*/frame_done column beats;
//        sram_we/sram_addr*/sram_d* to the banks; sram_q* registered bank outputs
module m4sram_xpose_ctrl
  import m4sram_xpose_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_d0,
  input  logic [DW-1:0] in_d1,
  input  logic [DW-1:0] in_d2,
  input  logic [DW-1:0] in_d3,
  output logic          out_valid,
  output logic [DW-1:0] out_d0,
  output logic [DW-1:0] out_d1,
  output logic [DW-1:0] out_d2,
  output logic [DW-1:0] out_d3,
  output logic          frame_done,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr0,
  output logic [AW-1:0] sram_addr1,
  output logic [AW-1:0] sram_addr2,
  output logic [AW-1:0] sram_addr3,
  output logic [DW-1:0] sram_d0,
  output logic [DW-1:0] sram_d1,
  output logic [DW-1:0] sram_d2,
  output logic [DW-1:0] sram_d3,
  input  logic [DW-1:0] sram_q0,
  input  logic [DW-1:0] sram_q1,
  input  logic [DW-1:0] sram_q2,
  input  logic [DW-1:0] sram_q3
);
  state_t        state, state_nx;
  logic [AW-1:0] wr_row, rd_col, rd_col_d;
  logic          rd_pend, wr_fire, rd_issue;
  logic [DW-1:0] wr_d [N];
  logic [DW-1:0] sd [N];
  logic [AW-1:0] addr [N];
  assign in_ready = state == WR;
  assign wr_fire = in_ready && in_valid;
  assign rd_issue = state == RD;
  assign sram_we = wr_fire;
  assign out_valid = rd_pend;
  assign frame_done = rd_pend && &rd_col_d;
  always_comb state_nx = in_ready ? (wr_fire && &wr_row ? RD : WR) : (&rd_col ? WR : RD);
  // Row and column counters wrap mod 4, so no explicit clear is needed between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WR;
      wr_row <= '0;
      rd_col <= '0;
      rd_pend <= 1'b0;
      rd_col_d <= '0;
    end else begin
      state <= state_nx;
      wr_row <= wr_row + AW'(wr_fire);
      rd_col <= rd_col + AW'(rd_issue);
      rd_pend <= rd_issue;
      rd_col_d <= rd_col;
    end
  end
  // Row r is written diagonally: bank b holds column (b-r), so column c lives in bank b at row (b-c).
  m4sram_xpose_ctrl_rot4 u_wr_rot (
    .d0(in_d0), .d1(in_d1), .d2(in_d2), .d3(in_d3),
    .amt(wr_row), .dir(1'b0),
    .q0(wr_d[0]), .q1(wr_d[1]), .q2(wr_d[2]), .q3(wr_d[3])
  );
  m4sram_xpose_ctrl_rot4 u_rd_rot (
    .d0(sram_q0), .d1(sram_q1), .d2(sram_q2), .d3(sram_q3),
    .amt(rd_col_d), .dir(1'b1),
    .q0(out_d0), .q1(out_d1), .q2(out_d2), .q3(out_d3)
  );
  for (genvar i = 0; i < N; i++) begin : g_bank
    assign addr[i] = wr_fire ? wr_row : rd_issue ? AW'(i) - rd_col : '0;
    assign sd[i] = wr_fire ? wr_d[i] : '0;
  end
  assign sram_addr0 = addr[0];
  assign sram_addr1 = addr[1];
  assign sram_addr2 = addr[2];
  assign sram_addr3 = addr[3];
  assign sram_d0 = sd[0];
  assign sram_d1 = sd[1];
  assign sram_d2 = sd[2];
  assign sram_d3 = sd[3];
endmodule

// File: tb/tb_m4sram_xpose_ctrl.sv
// tb_m4sram_xpose_ctrl: self-checking bench with SRAM model and frame-level reference model
module tb_m4sram_xpose_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [63:0] in_d [4];
  logic in_ready, out_valid, frame_done, sram_we;
  logic [63:0] out_d [4];
  logic [63:0] sram_d [4];
  logic [63:0] sram_q [4];
  logic [1:0] sram_addr [4];
  logic [63:0] mem [4][4];

  always #5 clk = ~clk;

  m4sram_xpose_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_d0(in_d[0]), .in_d1(in_d[1]), .in_d2(in_d[2]), .in_d3(in_d[3]),
    .out_valid(out_valid),
    .out_d0(out_d[0]), .out_d1(out_d[1]), .out_d2(out_d[2]), .out_d3(out_d[3]),
    .frame_done(frame_done), .sram_we(sram_we),
    .sram_addr0(sram_addr[0]), .sram_addr1(sram_addr[1]),
    .sram_addr2(sram_addr[2]), .sram_addr3(sram_addr[3]),
    .sram_d0(sram_d[0]), .sram_d1(sram_d[1]), .sram_d2(sram_d[2]), .sram_d3(sram_d[3]),
    .sram_q0(sram_q[0]), .sram_q1(sram_q[1]), .sram_q2(sram_q[2]), .sram_q3(sram_q[3])
  );

  // Banked SRAM: registered read, output holds during a write cycle.
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (sram_we) mem[b][sram_addr[b]] <= sram_d[b];
      else sram_q[b] <= mem[b][sram_addr[b]];

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model: a frame is a 4x4 matrix of accepted rows; once the 4th row lands,
  // the controller is unavailable for 4 cycles and column k appears 2+k cycles later.
  int cyc = 0;
  int rows, busy, rdy_low;
  bit ev [16];
  bit efd [16];
  logic [63:0] ed [16][4];
  logic [63:0] mat [4][4];
  logic s_ready, s_ov, s_fd;
  logic [63:0] s_od [4];

  task automatic mreset();
    rows = 0;
    busy = 0;
    for (int i = 0; i < 16; i++) begin
      ev[i] = 0;
      efd[i] = 0;
    end
  endtask

  task automatic cycle(input bit v);
    int s;
    bit rdy, acc;
    int ea;
    s = cyc % 16;
    in_valid = v;
    @(negedge clk);
    rdy = busy == 0;
    acc = v && rdy;
    s_ready = in_ready;
    s_ov = out_valid;
    s_fd = frame_done;
    for (int r = 0; r < 4; r++) s_od[r] = out_d[r];
    if (!in_ready) rdy_low++;
    chk("in_ready", in_ready, rdy);
    chk("sram_we", sram_we, acc);
    chk("out_valid", out_valid, ev[s]);
    chk("frame_done", frame_done, efd[s]);
    if (ev[s]) for (int r = 0; r < 4; r++) chk("out_d", out_d[r], ed[s][r]);
    for (int b = 0; b < 4; b++) begin
      ea = acc ? rows : busy > 0 ? ((b - (4 - busy)) & 3) : 0;
      chk("sram_addr", sram_addr[b], 64'(ea));
      chk("sram_d", sram_d[b], acc ? in_d[(b - rows) & 3] : 64'd0);
    end
    ev[s] = 0;
    efd[s] = 0;
    if (acc) begin
      for (int c = 0; c < 4; c++) mat[rows][c] = in_d[c];
      if (rows == 3) begin
        for (int k = 0; k < 4; k++) begin
          ev[(cyc + 2 + k) % 16] = 1;
          efd[(cyc + 2 + k) % 16] = k == 3;
          for (int r = 0; r < 4; r++) ed[(cyc + 2 + k) % 16][r] = mat[r][k];
        end
        busy = 4;
        rows = 0;
      end else rows++;
    end else if (busy > 0) busy--;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Present row r (pattern 0x..rc or random) and hold it with valid high until accepted.
  task automatic send_row(input int r, input bit rnd);
    bit done;
    bit ok;
    done = 0;
    for (int c = 0; c < 4; c++) in_d[c] = rnd ? {$urandom, $urandom} : 64'(r * 16 + c);
    for (int k = 0; k < 10 && !done; k++) begin
      ok = busy == 0;
      cycle(1);
      done = ok;
    end
    chk("row_accept", 64'(done), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0);
  endtask

  typedef struct {
    bit v;
    int row;
    bit rdy;
    bit ov;
    bit fd;
    int col;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int lo;
    tbl[0] = '{1, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 0, 0, 0};
    tbl[2] = '{1, 2, 1, 0, 0, 0};
    tbl[3] = '{1, 3, 1, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 1, 0, 1};
    tbl[7] = '{0, 0, 0, 1, 0, 2};
    tbl[8] = '{0, 0, 1, 1, 1, 3};
    tbl[9] = '{0, 0, 1, 0, 0, 0};
    for (int c = 0; c < 4; c++) in_d[c] = '0;
    rdy_low = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sram_we", sram_we, 0);
    rst_n = 1'b1;

    // Single continuous frame, explicit vectors.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].v) for (int c = 0; c < 4; c++) in_d[c] = 64'(tbl[i].row * 16 + c);
      cycle(tbl[i].v);
      chk("tbl_ready", s_ready, tbl[i].rdy);
      chk("tbl_out_valid", s_ov, tbl[i].ov);
      chk("tbl_frame_done", s_fd, tbl[i].fd);
      if (tbl[i].ov) for (int r = 0; r < 4; r++) chk("tbl_out_d", s_od[r], 64'(r * 16 + tbl[i].col));
    end

    // Gapped input: 3 idle cycles between rows 1 and 2.
    send_row(0, 0);
    send_row(1, 0);
    idle(3);
    send_row(2, 0);
    send_row(3, 0);
    idle(6);

    // Back-to-back with valid held through RD: frame B row 0 lands on frame A's last beat.
    send_row(0, 1);
    send_row(1, 1);
    send_row(2, 1);
    send_row(3, 1);
    lo = rdy_low;
    send_row(0, 1);
    chk("backpressure_cycles", 64'(rdy_low - lo), 64'd4);
    chk("b2b_last_beat", s_fd, 1);
    send_row(1, 1);
    send_row(2, 1);
    send_row(3, 1);
    idle(6);

    // Reset after column 1 has been issued.
    send_row(0, 0);
    send_row(1, 0);
    send_row(2, 0);
    send_row(3, 0);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("midrd_out_valid", out_valid, 0);
    chk("midrd_frame_done", frame_done, 0);
    chk("midrd_in_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("midrd_hold_fd", frame_done, 0);
      chk("midrd_hold_ov", out_valid, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mreset();
    idle(1);
    for (int r = 0; r < 4; r++) send_row(r, 1);
    idle(6);

    // Random frames with random gaps.
    repeat (8) begin
      for (int r = 0; r < 4; r++) begin
        send_row(r, 1);
        idle($urandom_range(0, 2));
      end
    end
    idle(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
